// File: rtl/poly_pitch_generator_if.sv
// Bus-side signals of the polyphonic pitch generator: CPU write port, busy poll, buzzer output.
// The CPU side takes the master modport; the generator takes the slave modport.
interface poly_pitch_generator_if #(
  parameter int CHANNELS = 4
) ();
  logic                we;
  logic [2:0]          addr;
  logic [31:0]         wdata;
  logic [31:0]         rdata;
  logic [CHANNELS-1:0] busy;
  logic                wave;

  modport master (output we, addr, wdata, input  rdata, busy, wave);
  modport slave  (input  we, addr, wdata, output rdata, busy, wave);
endinterface

// File: rtl/poly_pitch_generator.sv
// CHANNELS self-timed square-wave voices, written over the MIO bus and mixed into a
// 1-bit sigma-delta stream for the buzzer.
module poly_pitch_generator #(
  parameter int CHANNELS = 4,
  parameter int TICK_DIV = 100000,
  parameter int HP_W     = 21,
  parameter int DUR_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  poly_pitch_generator_if.slave bus
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = $clog2(2 * CHANNELS) + 1;

  logic [TW-1:0]       tick_cnt;
  logic                tick;
  logic [HP_W-1:0]     cnt     [CHANNELS];
  logic [HP_W-1:0]     half    [CHANNELS];
  logic [DUR_W-1:0]    dur_rem [CHANNELS];
  logic [CHANNELS-1:0] square;
  logic [CHANNELS-1:0] busy_r;
  logic [AW-1:0]       acc;
  logic [AW-1:0]       sum;
  logic [AW-1:0]       nxt;
  logic                wave_r;
  logic [HP_W-1:0]     new_half;
  logic                new_busy;
  logic                unused_wdata;

  // Octave-0 half periods (C1..B1) at a 100 MHz clock.
  function automatic logic [20:0] base_half(input logic [3:0] s);
    case (s)
      4'd0:    base_half = 21'd1528903;
      4'd1:    base_half = 21'd1443092;
      4'd2:    base_half = 21'd1362097;
      4'd3:    base_half = 21'd1285649;
      4'd4:    base_half = 21'd1213491;
      4'd5:    base_half = 21'd1145383;
      4'd6:    base_half = 21'd1081097;
      4'd7:    base_half = 21'd1020420;
      4'd8:    base_half = 21'd963148;
      4'd9:    base_half = 21'd909091;
      4'd10:   base_half = 21'd858068;
      4'd11:   base_half = 21'd809908;
      default: base_half = '0;
    endcase
  endfunction

  assign tick         = (tick_cnt == TW'(TICK_DIV - 1));
  assign unused_wdata = ^bus.wdata[31:24];

  always_comb begin
    new_half = HP_W'(base_half(bus.wdata[3:0]) >> bus.wdata[7:4]);
    new_busy = (bus.wdata[3:0] < 4'd12);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt <= '0;
    else        tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
  end

  // A write takes priority over both the phase counter and the duration tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        cnt[i]     <= '0;
        half[i]    <= '0;
        dur_rem[i] <= '0;
      end
      square <= '0;
      busy_r <= '0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (bus.we && bus.addr == 3'(i)) begin
          cnt[i]     <= '0;
          square[i]  <= 1'b0;
          half[i]    <= new_half;
          dur_rem[i] <= DUR_W'(bus.wdata[23:8]);
          busy_r[i]  <= new_busy;
        end else if (busy_r[i]) begin
          if (tick && dur_rem[i] == DUR_W'(1)) begin
            busy_r[i]  <= 1'b0;
            square[i]  <= 1'b0;
            cnt[i]     <= '0;
            dur_rem[i] <= '0;
          end else begin
            if (tick && dur_rem[i] != '0) dur_rem[i] <= dur_rem[i] - DUR_W'(1);
            if (cnt[i] == half[i] - HP_W'(1)) begin
              square[i] <= ~square[i];
              cnt[i]    <= '0;
            end else begin
              cnt[i] <= cnt[i] + HP_W'(1);
            end
          end
        end
      end
    end
  end

  always_comb begin
    sum = AW'($countones(square & busy_r));
    nxt = acc + sum;
  end

  // First-order sigma-delta: ones density tracks active-high voices / CHANNELS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      wave_r <= 1'b0;
    end else if (nxt >= AW'(CHANNELS)) begin
      acc    <= nxt - AW'(CHANNELS);
      wave_r <= 1'b1;
    end else begin
      acc    <= nxt;
      wave_r <= 1'b0;
    end
  end

  assign bus.busy  = busy_r;
  assign bus.wave  = wave_r;
  assign bus.rdata = 32'(busy_r);
endmodule

// File: tb/tb_poly_pitch_generator.sv
// Bench for poly_pitch_generator: per-voice timeline model (write edge, half period,
// tick-aligned end edge) plus a sigma-delta accumulator, checked every cycle.
module tb_poly_pitch_generator;
  localparam int CH = 4;
  localparam int TD = 100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  poly_pitch_generator_if #(.CHANNELS(CH)) bus ();

  poly_pitch_generator #(
    .CHANNELS(CH),
    .TICK_DIV(TD),
    .HP_W(21),
    .DUR_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: k = rising edges since reset release; each voice keeps its last write.
  int  k = 0;
  bit  v_valid [CH];
  bit  v_rest  [CH];
  int  v_kw    [CH];
  int  v_half  [CH];
  int  v_dur   [CH];
  int  m_acc   = 0;
  bit  m_wave  = 1'b0;
  int  m_sum;
  logic [CH-1:0] m_busy_vec;

  function automatic int base_of(int s);
    real f;
    f = 55.0 * (2.0 ** ((s - 9) / 12.0));
    return $rtoi(5.0e7 / f + 0.5);
  endfunction

  // Ticks fall on edges that are multiples of TD; a voice ends on its dur-th tick after the write.
  function automatic bit m_busy(int v, int kk);
    if (!v_valid[v] || v_rest[v]) return 1'b0;
    if (v_dur[v] == 0) return 1'b1;
    return kk < (v_kw[v] / TD + v_dur[v]) * TD;
  endfunction

  function automatic bit m_sq(int v, int kk);
    return m_busy(v, kk) && (((kk - v_kw[v]) / v_half[v]) % 2 == 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, k);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      k = 0;
      for (int i = 0; i < CH; i++) v_valid[i] = 1'b0;
      m_acc  = 0;
      m_wave = 1'b0;
    end else begin
      m_sum = 0;
      for (int i = 0; i < CH; i++) m_sum += int'(m_sq(i, k));
      if (m_acc + m_sum >= CH) begin
        m_wave = 1'b1;
        m_acc  = m_acc + m_sum - CH;
      end else begin
        m_wave = 1'b0;
        m_acc  = m_acc + m_sum;
      end
      k++;
      if (bus.we && bus.addr < CH) begin
        v_valid[bus.addr] = 1'b1;
        v_rest[bus.addr]  = (bus.wdata[3:0] >= 4'd12);
        v_kw[bus.addr]    = k;
        v_half[bus.addr]  = base_of(int'(bus.wdata[3:0])) >> bus.wdata[7:4];
        v_dur[bus.addr]   = int'(bus.wdata[23:8]);
      end
    end
    #1;
    for (int i = 0; i < CH; i++) m_busy_vec[i] = m_busy(i, k);
    check("busy", 32'(bus.busy), 32'(m_busy_vec));
    check("rdata", bus.rdata, 32'(m_busy_vec));
    check("wave", 32'(bus.wave), 32'(m_wave));
  end

  task automatic do_write(input int a, input int oct, input int semi, input int dur);
    bus.we    = 1'b1;
    bus.addr  = 3'(a);
    bus.wdata = {8'h00, 16'(dur), 4'(oct), 4'(semi)};
    @(negedge clk);
    bus.we = 1'b0;
  endtask

  int kw;
  int cnt_ones;
  int fall;
  int tick_edge;

  initial begin
    bus.we    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    check("model_base_A1", 32'(base_of(9)), 32'd909091);
    check("model_half_A7", 32'(base_of(9) >> 7), 32'd7102);
    check("model_half_C7", 32'(base_of(0) >> 7), 32'd11944);
    check("model_half_A15", 32'(base_of(9) >> 15), 32'd27);

    // Idle after reset
    repeat (1000) @(negedge clk);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_rdata", bus.rdata, 32'd0);
    check("idle_wave", 32'(bus.wave), 32'd0);

    // Single voice, oct15 A sustain: half 27, accumulator fresh at 0 -> first wave 1 four edges after the rise
    do_write(0, 15, 9, 0);
    kw = k;
    check("write_busy_next_edge", 32'(bus.busy), 32'b0001);
    repeat (30) @(negedge clk);
    check("first_rise_wave_lo", 32'(bus.wave), 32'd0);
    @(negedge clk);
    check("first_rise_wave_hi", 32'(bus.wave), 32'd1);

    // oct7 C with dur 3 on voice 1 ends 201..300 edges after the write
    do_write(1, 7, 0, 3);
    kw = k;
    for (int n = 0; n < 400 && bus.busy[1]; n++) @(negedge clk);
    fall = k - kw;
    check("dur3_fall_in_window", 32'(fall >= 201 && fall <= 300), 32'd1);
    do_write(0, 15, 12, 0);
    repeat (10) @(negedge clk);
    check("settled_busy", 32'(bus.busy), 32'd0);
    check("settled_wave", 32'(bus.wave), 32'd0);

    // Rest write drops busy; out-of-range address is ignored
    do_write(2, 14, 4, 0);
    repeat (20) @(negedge clk);
    do_write(2, 14, 13, 0);
    check("rest_drops_busy", 32'(bus.busy), 32'd0);
    do_write(3, 13, 2, 0);
    do_write(7, 15, 9, 5);
    check("addr7_ignored", 32'(bus.busy), 32'b1000);

    // Retrigger on the exact tick edge where dur_rem would hit 0
    do_write(2, 15, 7, 1);
    tick_edge = (k / TD + 1) * TD;
    for (int n = 0; n < 2 * TD && k + 1 < tick_edge; n++) @(negedge clk);
    do_write(2, 15, 7, 2);
    check("retrigger_on_tick_edge", 32'(k), 32'(tick_edge));
    check("retrigger_stays_busy", 32'(bus.busy[2]), 32'd1);

    // Two voices high together -> exactly half density
    for (int i = 0; i < CH; i++) do_write(i, 0, 12, 0);
    do_write(0, 12, 9, 0);
    kw = k;
    do_write(1, 12, 9, 0);
    repeat (299) @(negedge clk);
    cnt_ones = 0;
    repeat (100) begin
      @(negedge clk);
      cnt_ones += int'(bus.wave);
    end
    check("density_2_of_4", 32'(cnt_ones), 32'd50);

    // All four high together -> wave held at 1
    do_write(0, 12, 9, 0);
    do_write(1, 12, 9, 0);
    do_write(2, 12, 9, 0);
    do_write(3, 12, 9, 0);
    repeat (299) @(negedge clk);
    cnt_ones = 0;
    repeat (100) begin
      @(negedge clk);
      cnt_ones += int'(bus.wave);
    end
    check("density_4_of_4", 32'(cnt_ones), 32'd100);

    // Asynchronous reset mid-note
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(bus.busy), 32'd0);
    check("async_rst_rdata", bus.rdata, 32'd0);
    check("async_rst_wave", 32'(bus.wave), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomised writes, including out-of-range addresses, rests and short durations
    repeat (300) begin
      repeat ($urandom_range(0, 15)) @(negedge clk);
      do_write(int'($urandom_range(0, 7)), int'($urandom_range(10, 15)),
               int'($urandom_range(0, 15)), int'($urandom_range(0, 4)));
    end
    repeat (500) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
